// File: rtl/uart_pkg.sv
// uart_pkg: constants shared by the UART transmit feeder.
//   - read-control FSM state encodings
//   - default byte width and FIFO depth
package uart_pkg;

  localparam int DEF_DATA_WIDTH = 8;
  localparam int DEF_FIFO_DEPTH = 8;

  localparam logic [1:0] IDLE      = 2'b00;
  localparam logic [1:0] ISSUE     = 2'b01;
  localparam logic [1:0] WAIT_BUSY = 2'b10;
  localparam logic [1:0] WAIT_DONE = 2'b11;

endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: single-clock byte FIFO with wrap-bit pointers.
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   WR_DATA/WR_EN enqueue side; a write while FULL is dropped and pulses OVERFLOW
//   RD_EN         pop request (ignored while EMPTY)
//   RD_DATA       head entry, valid whenever EMPTY=0
//   FULL/EMPTY    registered occupancy flags for the current pointer state
//   OVERFLOW      one-cycle pulse for a discarded write
//   COUNT         occupancy, present only with UART_TX_FEEDER_COUNT_EN
module sync_fifo
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_WIDTH-1:0]         WR_DATA,
  input  logic                          WR_EN,
  input  logic                          RD_EN,
  output logic [DATA_WIDTH-1:0]         RD_DATA,
  output logic                          FULL,
  output logic                          EMPTY,
  output logic                          OVERFLOW
`ifdef UART_TX_FEEDER_COUNT_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT
`endif
);

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [DATA_WIDTH-1:0] mem [FIFO_DEPTH];
  logic [AW:0]           wptr, rptr, wptr_nxt, rptr_nxt;
  logic                  do_wr, do_rd;

  // Both qualifiers use the flags of the current state, so a pop never
  // frees room for a same-cycle write and a fresh byte is never popped
  // on the edge that writes it.
  assign do_wr = WR_EN && !FULL;
  assign do_rd = RD_EN && !EMPTY;

  assign wptr_nxt = wptr + {{AW{1'b0}}, do_wr};
  assign rptr_nxt = rptr + {{AW{1'b0}}, do_rd};

  assign RD_DATA = mem[rptr[AW-1:0]];

  always_ff @(posedge CLK) begin
    if (!RST && do_wr) mem[wptr[AW-1:0]] <= WR_DATA;
  end

  // Flags are registered from the next-state pointers so they line up
  // exactly with the pointer registers after each edge.
  always_ff @(posedge CLK) begin
    if (RST) begin
      wptr     <= '0;
      rptr     <= '0;
      FULL     <= 1'b0;
      EMPTY    <= 1'b1;
      OVERFLOW <= 1'b0;
    end else begin
      wptr     <= wptr_nxt;
      rptr     <= rptr_nxt;
      FULL     <= (wptr_nxt[AW-1:0] == rptr_nxt[AW-1:0]) && (wptr_nxt[AW] != rptr_nxt[AW]);
      EMPTY    <= (wptr_nxt == rptr_nxt);
      OVERFLOW <= WR_EN && FULL;
    end
  end

`ifdef UART_TX_FEEDER_COUNT_EN
  always_ff @(posedge CLK) begin
    if (RST) COUNT <= '0;
    else     COUNT <= wptr_nxt - rptr_nxt;
  end
`endif

endmodule

// File: rtl/uart_tx_feeder.sv
// uart_tx_feeder: buffers bytes and hands them to the UART transmitter one
// frame at a time, pacing on the transmitter Busy flag.
// Optional feature macro: UART_TX_FEEDER_COUNT_EN (adds COUNT occupancy port).
// Ports:
//   CLK, RST      clock, synchronous active-high reset
//   WR_DATA/WR_EN system-side enqueue
//   FULL/EMPTY    FIFO occupancy flags
//   OVERFLOW      pulse when a write is dropped because the FIFO is full
//   P_DATA        last issued byte, held until the next issue
//   DATA_VALID    one-cycle issue strobe to the transmitter
//   Busy          transmitter busy flag
//   COUNT         FIFO occupancy (feature build only)
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int FIFO_DEPTH = DEF_FIFO_DEPTH
) (
  input  logic                          CLK,
  input  logic                          RST,
  input  logic [DATA_WIDTH-1:0]         WR_DATA,
  input  logic                          WR_EN,
  output logic                          FULL,
  output logic                          EMPTY,
  output logic                          OVERFLOW,
  output logic [DATA_WIDTH-1:0]         P_DATA,
  output logic                          DATA_VALID,
  input  logic                          Busy
`ifdef UART_TX_FEEDER_COUNT_EN
  ,
  output logic [$clog2(FIFO_DEPTH):0]   COUNT
`endif
);

  logic [1:0]            state;
  logic [DATA_WIDTH-1:0] head;
  logic                  pop;

  // Only pop from IDLE; after a reset with Busy still high this also keeps
  // us from issuing into a frame the transmitter has not finished.
  assign pop = (state == IDLE) && !EMPTY && !Busy;

`ifdef UART_TX_FEEDER_COUNT_EN
  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK(CLK), .RST(RST), .WR_DATA(WR_DATA), .WR_EN(WR_EN),
    .RD_EN(pop), .RD_DATA(head),
    .FULL(FULL), .EMPTY(EMPTY), .OVERFLOW(OVERFLOW), .COUNT(COUNT)
  );
`else
  sync_fifo #(.DATA_WIDTH(DATA_WIDTH), .FIFO_DEPTH(FIFO_DEPTH)) u_fifo (
    .CLK(CLK), .RST(RST), .WR_DATA(WR_DATA), .WR_EN(WR_EN),
    .RD_EN(pop), .RD_DATA(head),
    .FULL(FULL), .EMPTY(EMPTY), .OVERFLOW(OVERFLOW)
  );
`endif

  // WAIT_BUSY waits for the transmitter to acknowledge the frame before
  // WAIT_DONE waits for it to finish, so a strobe can never land mid-frame.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state      <= IDLE;
      P_DATA     <= '0;
      DATA_VALID <= 1'b0;
    end else begin
      DATA_VALID <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            P_DATA     <= head;
            DATA_VALID <= 1'b1;
            state      <= ISSUE;
          end
        end
        ISSUE:     state <= WAIT_BUSY;
        WAIT_BUSY: if (Busy)  state <= WAIT_DONE;
        WAIT_DONE: if (!Busy) state <= IDLE;
        default:   state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb_uart_tx_feeder: directed bench for uart_tx_feeder with a simple
// transmitter Busy model (Busy rises the cycle after a strobe, lasts 10).
module tb_uart_tx_feeder;

  localparam int DW = 8;
  localparam int DEPTH = 8;

  logic          CLK = 1'b0;
  logic          RST;
  logic [DW-1:0] WR_DATA;
  logic          WR_EN;
  logic          FULL, EMPTY, OVERFLOW, DATA_VALID;
  logic [DW-1:0] P_DATA;
  logic          Busy;
  logic          busy_hold;
`ifdef UART_TX_FEEDER_COUNT_EN
  logic [$clog2(DEPTH):0] COUNT;
`endif

  int n_chk = 0;
  int n_err = 0;
  int viol = 0;
  int ovf_cnt = 0;
  int bcnt = 0;
  logic dv_q = 1'b0;
  logic [DW-1:0] issued[$];

  uart_tx_feeder #(.DATA_WIDTH(DW), .FIFO_DEPTH(DEPTH)) dut (
    .CLK(CLK), .RST(RST), .WR_DATA(WR_DATA), .WR_EN(WR_EN),
    .FULL(FULL), .EMPTY(EMPTY), .OVERFLOW(OVERFLOW),
    .P_DATA(P_DATA), .DATA_VALID(DATA_VALID), .Busy(Busy)
`ifdef UART_TX_FEEDER_COUNT_EN
    , .COUNT(COUNT)
`endif
  );

  always #5 CLK = ~CLK;

  // Transmitter model: not reset by RST, so Busy survives a feeder reset.
  always @(posedge CLK) begin
    if (DATA_VALID)    bcnt <= 10;
    else if (bcnt != 0) bcnt <= bcnt - 1;
  end
  assign Busy = busy_hold | (bcnt != 0);

  // Strobe monitor: record issued bytes, flag back-to-back or busy strobes.
  always @(negedge CLK) begin
    if (DATA_VALID) begin
      issued.push_back(P_DATA);
      if (dv_q || Busy) viol <= viol + 1;
    end
    dv_q <= DATA_VALID;
    if (OVERFLOW) ovf_cnt <= ovf_cnt + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_issued(input int target, input int budget, input string tag);
    int k = 0;
    while (issued.size() < target && k < budget) begin
      @(negedge CLK);
      k++;
    end
    @(negedge CLK);
    chk(tag, issued.size(), target);
  endtask

  initial begin
    int base, ovf0, i, k;
    RST = 1'b1; WR_EN = 1'b0; WR_DATA = '0; busy_hold = 1'b0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    chk("rst_empty", EMPTY, 1);
    chk("rst_full", FULL, 0);
    chk("rst_dv", DATA_VALID, 0);
    chk("rst_pdata", P_DATA, 8'h00);
    chk("rst_ovf", OVERFLOW, 0);
`ifdef UART_TX_FEEDER_COUNT_EN
    chk("rst_count", COUNT, 0);
`endif
    RST = 1'b0;
    repeat (20) @(negedge CLK);
    chk("idle_no_issue", issued.size(), 0);

    // Single byte: strobe in the cycle after the second edge.
    WR_EN = 1'b1; WR_DATA = 8'hA5;
    @(negedge CLK); WR_EN = 1'b0;
    chk("lat_edge_n", DATA_VALID, 0);
    chk("lat_empty_clr", EMPTY, 0);
    @(negedge CLK);
    chk("lat_dv", DATA_VALID, 1);
    chk("lat_pdata", P_DATA, 8'hA5);
    @(negedge CLK);
    chk("lat_dv_one", DATA_VALID, 0);
    chk("lat_pdata_hold", P_DATA, 8'hA5);
    repeat (20) @(negedge CLK);

    // Back-to-back writes through the Busy model.
    base = issued.size();
    WR_EN = 1'b1; WR_DATA = 8'h11; @(negedge CLK);
    WR_DATA = 8'h22; @(negedge CLK);
    WR_DATA = 8'h33; @(negedge CLK);
    WR_EN = 1'b0;
    wait_issued(base + 3, 100, "b2b_count");
    chk("b2b_0", issued[base], 8'h11);
    chk("b2b_1", issued[base+1], 8'h22);
    chk("b2b_2", issued[base+2], 8'h33);
    repeat (20) @(negedge CLK);

    // Fill and overflow with the transmitter stalled.
    busy_hold = 1'b1;
    @(negedge CLK);
    base = issued.size();
    ovf0 = ovf_cnt;
    for (int j = 0; j < 9; j++) begin
      WR_EN = 1'b1; WR_DATA = j[7:0];
      @(negedge CLK);
      if (j == 6) chk("full_after7", FULL, 0);
      if (j == 7) chk("full_after8", FULL, 1);
      if (j == 8) chk("ovf_pulse", OVERFLOW, 1);
    end
    WR_EN = 1'b0;
    @(negedge CLK);
    chk("ovf_clear", OVERFLOW, 0);
    chk("full_hold", FULL, 1);
`ifdef UART_TX_FEEDER_COUNT_EN
    chk("count_full", COUNT, 8);
`endif
    busy_hold = 1'b0;
    wait_issued(base + 8, 300, "fill_drain");
    chk("ovf_once", ovf_cnt - ovf0, 1);
    for (int j = 0; j < 8; j++) chk("fill_order", issued[base+j], j);
    repeat (20) @(negedge CLK);
    chk("no_byte8", issued.size(), base + 8);
    chk("fill_empty", EMPTY, 1);

    // Wrap-around: 20 bytes paced on FULL.
    base = issued.size();
    ovf0 = ovf_cnt;
    i = 0; k = 0;
    while (i < 20 && k < 2000) begin
      if (!FULL) begin
        WR_EN = 1'b1; WR_DATA = i[7:0]; i++;
      end else begin
        WR_EN = 1'b0;
      end
      @(negedge CLK);
      k++;
    end
    WR_EN = 1'b0;
    chk("wrap_writes", i, 20);
    wait_issued(base + 20, 600, "wrap_drain");
    for (int j = 0; j < 20; j++) chk("wrap_order", issued[base+j], j);
    chk("wrap_no_ovf", ovf_cnt - ovf0, 0);
    repeat (20) @(negedge CLK);

    // Reset in WAIT_DONE with three bytes queued.
    base = issued.size();
    WR_EN = 1'b1; WR_DATA = 8'h41; @(negedge CLK);
    WR_DATA = 8'h42; @(negedge CLK);
    WR_DATA = 8'h43; @(negedge CLK);
    WR_DATA = 8'h44; @(negedge CLK);
    WR_EN = 1'b0;
    repeat (3) @(negedge CLK);
    chk("pre_rst_busy", Busy, 1);
    chk("pre_rst_queued", EMPTY, 0);
`ifdef UART_TX_FEEDER_COUNT_EN
    chk("pre_rst_count", COUNT, 3);
`endif
    RST = 1'b1;
    @(negedge CLK);
    RST = 1'b0;
    chk("mid_rst_empty", EMPTY, 1);
    chk("mid_rst_dv", DATA_VALID, 0);
    chk("mid_rst_full", FULL, 0);
    repeat (40) @(negedge CLK);
    chk("mid_rst_no_issue", issued.size(), base + 1);
    chk("mid_rst_first", issued[base], 8'h41);
    WR_EN = 1'b1; WR_DATA = 8'h5A; @(negedge CLK);
    WR_EN = 1'b0;
    wait_issued(base + 2, 50, "post_rst_issue");
    chk("post_rst_byte", issued[issued.size()-1], 8'h5A);

    repeat (20) @(negedge CLK);
    chk("strobe_rules", viol, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
